// File: rtl/fetch_decode_skid_register.sv
// ============================================================================
// fetch_decode_skid_register : IF/ID pipeline register, valid/ready, skid.
// Revision 1.0
// ============================================================================
`default_nettype none

module fetch_decode_skid_register #(
   parameter int                 INSTR_W   = 32,
   parameter int                 PC_W      = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013,
   parameter logic [PC_W-1:0]    RESET_PC  = '0,
   parameter bit                 SKID_EN   = 1'b1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               f_valid_i,
   output logic               f_ready_o,
   input  logic [INSTR_W-1:0] f_instruction_i,
   input  logic [PC_W-1:0]    f_pcsrc_i,
   output logic               fd_valid_o,
   input  logic               fd_ready_i,
   output logic [INSTR_W-1:0] fd_instruction_o,
   output logic [PC_W-1:0]    fd_pcsrc_o,
   input  logic               stall_i,
   input  logic               flush_i,
   output logic [1:0]         occupancy_o
);

   logic               main_valid_q, main_valid_d;
   logic [INSTR_W-1:0] main_instr_q, main_instr_d;
   logic [PC_W-1:0]    main_pc_q,    main_pc_d;
   logic               skid_valid_q, skid_valid_d;
   logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
   logic [PC_W-1:0]    skid_pc_q,    skid_pc_d;
   logic               f_ready_q,    f_ready_d;
   logic [1:0]         occupancy_q,  occupancy_d;
   logic               accept, consume;

   generate
      if (SKID_EN) begin : g_skid_ready
         assign f_ready_o = f_ready_q;
      end else begin : g_single_ready
         assign f_ready_o = ~main_valid_q | (fd_ready_i & ~stall_i);
      end
   endgenerate

   assign accept  = f_valid_i & f_ready_o & ~flush_i;
   assign consume = main_valid_q & fd_ready_i & ~stall_i;

   always_comb begin
      main_valid_d = main_valid_q;
      main_instr_d = main_instr_q;
      main_pc_d    = main_pc_q;
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;

      if (flush_i) begin
         // PC is deliberately left holding its last value
         main_valid_d = 1'b0;
         main_instr_d = NOP_INSTR;
         skid_valid_d = 1'b0;
      end else if (SKID_EN && skid_valid_q) begin
         if (consume) begin
            main_valid_d = 1'b1;
            main_instr_d = skid_instr_q;
            main_pc_d    = skid_pc_q;
            skid_valid_d = 1'b0;
         end
      end else if (accept && (!main_valid_q || consume)) begin
         main_valid_d = 1'b1;
         main_instr_d = f_instruction_i;
         main_pc_d    = f_pcsrc_i;
      end else if (accept) begin
         // Main is busy and not draining: only reachable with the skid present
         skid_valid_d = 1'b1;
         skid_instr_d = f_instruction_i;
         skid_pc_d    = f_pcsrc_i;
      end else if (consume) begin
         main_valid_d = 1'b0;
         main_instr_d = NOP_INSTR;
      end

      f_ready_d   = ~skid_valid_d;
      occupancy_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         main_valid_q <= 1'b0;
         main_instr_q <= NOP_INSTR;
         main_pc_q    <= RESET_PC;
         skid_valid_q <= 1'b0;
         skid_instr_q <= NOP_INSTR;
         skid_pc_q    <= RESET_PC;
         f_ready_q    <= 1'b1;
         occupancy_q  <= 2'd0;
      end else begin
         main_valid_q <= main_valid_d;
         main_instr_q <= main_instr_d;
         main_pc_q    <= main_pc_d;
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         f_ready_q    <= f_ready_d;
         occupancy_q  <= occupancy_d;
      end
   end

   assign fd_valid_o       = main_valid_q;
   assign fd_instruction_o = main_instr_q;
   assign fd_pcsrc_o       = main_pc_q;
   assign occupancy_o      = occupancy_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode_skid_register.sv
// ============================================================================
// tb_fetch_decode_skid_register : scoreboard bench for both skid configurations.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fetch_decode_skid_register;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        f_valid   [2];
   logic        f_ready   [2];
   logic [31:0] f_instr   [2];
   logic [31:0] f_pc      [2];
   logic        fd_valid  [2];
   logic        fd_ready  [2];
   logic [31:0] fd_instr  [2];
   logic [31:0] fd_pc     [2];
   logic        stall     [2];
   logic        flush     [2];
   logic [1:0]  occ       [2];

   int checks = 0;
   int errors = 0;
   int consumed0 = 0;
   logic [63:0] q1 [$];
   logic [63:0] q0 [$];

   always #5 clk = ~clk;

   fetch_decode_skid_register #(.SKID_EN(1'b1)) u_dut_skid (
      .clk_i(clk), .rst_i(rst),
      .f_valid_i(f_valid[1]), .f_ready_o(f_ready[1]),
      .f_instruction_i(f_instr[1]), .f_pcsrc_i(f_pc[1]),
      .fd_valid_o(fd_valid[1]), .fd_ready_i(fd_ready[1]),
      .fd_instruction_o(fd_instr[1]), .fd_pcsrc_o(fd_pc[1]),
      .stall_i(stall[1]), .flush_i(flush[1]), .occupancy_o(occ[1])
   );

   fetch_decode_skid_register #(.SKID_EN(1'b0)) u_dut_single (
      .clk_i(clk), .rst_i(rst),
      .f_valid_i(f_valid[0]), .f_ready_o(f_ready[0]),
      .f_instruction_i(f_instr[0]), .f_pcsrc_i(f_pc[0]),
      .fd_valid_o(fd_valid[0]), .fd_ready_i(fd_ready[0]),
      .fd_instruction_o(fd_instr[0]), .fd_pcsrc_o(fd_pc[0]),
      .stall_i(stall[0]), .flush_i(flush[0]), .occupancy_o(occ[0])
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus on instance s, checking outputs against the model
   // before the edge and updating the model with what the edge should do.
   task automatic step(input bit s, input logic v, input logic [31:0] pc,
                       input logic rdy, input logic stl, input logic fl);
      int          sz;
      logic [63:0] fr;
      logic        er;
      logic [31:0] ins;
      ins = 32'h00A00093 ^ {pc[23:0], 8'h00};
      f_valid[s] = v;  f_instr[s] = ins; f_pc[s] = pc;
      fd_ready[s] = rdy; stall[s] = stl; flush[s] = fl;
      #1;
      sz = s ? q1.size() : q0.size();
      fr = (sz > 0) ? (s ? q1[0] : q0[0]) : 64'd0;
      er = s ? (sz < 2) : (sz == 0 || (rdy && !stl));
      chk("f_ready", {63'd0, f_ready[s]}, {63'd0, er});
      chk("fd_valid", {63'd0, fd_valid[s]}, {63'd0, sz > 0});
      chk("occupancy", {62'd0, occ[s]}, sz);
      if (sz > 0) begin
         chk("fd_instruction", {32'd0, fd_instr[s]}, {32'd0, fr[63:32]});
         chk("fd_pcsrc", {32'd0, fd_pc[s]}, {32'd0, fr[31:0]});
      end else begin
         chk("fd_instruction_nop", {32'd0, fd_instr[s]}, {32'd0, NOP});
      end
      if (sz > 0 && rdy && !stl) begin
         if (s) void'(q1.pop_front());
         else begin void'(q0.pop_front()); consumed0++; end
      end
      if (fl) begin
         if (s) q1.delete(); else q0.delete();
      end else if (v && er) begin
         if (s) q1.push_back({ins, pc}); else q0.push_back({ins, pc});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         f_valid[i] = 1'b0; f_instr[i] = '0; f_pc[i] = '0;
         fd_ready[i] = 1'b0; stall[i] = 1'b0; flush[i] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_fd_valid", {63'd0, fd_valid[1]}, 64'd0);
      chk("rst_fd_instr", {32'd0, fd_instr[1]}, {32'd0, NOP});
      chk("rst_fd_pc", {32'd0, fd_pc[1]}, 64'd0);
      chk("rst_occ", {62'd0, occ[1]}, 64'd0);
      chk("rst_f_ready", {63'd0, f_ready[1]}, 64'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single transfer
      step(1, 1, 32'h100, 1, 0, 0);
      step(1, 0, 32'h0,   1, 0, 0);
      step(1, 0, 32'h0,   1, 0, 0);

      // Back-pressure: fill both entries, 0x108 held off until release
      step(1, 1, 32'h100, 0, 0, 0);
      step(1, 1, 32'h104, 0, 0, 0);
      step(1, 1, 32'h108, 0, 0, 0);
      step(1, 1, 32'h108, 1, 0, 0);
      step(1, 1, 32'h108, 1, 0, 0);
      step(1, 0, 32'h0,   1, 0, 0);
      step(1, 0, 32'h0,   1, 0, 0);

      // Stall with FULL1 at 0x200: one accept lands in skid, then ready drops
      step(1, 1, 32'h200, 0, 0, 0);
      step(1, 1, 32'h204, 1, 1, 0);
      step(1, 1, 32'h208, 1, 1, 0);
      step(1, 1, 32'h208, 1, 1, 0);
      step(1, 1, 32'h208, 1, 0, 0);
      step(1, 1, 32'h208, 1, 0, 0);
      step(1, 0, 32'h0,   1, 0, 0);
      step(1, 0, 32'h0,   1, 0, 0);

      // Flush with accept from FULL2: 0x3F0 must never appear
      step(1, 1, 32'h300, 0, 0, 0);
      step(1, 1, 32'h304, 0, 0, 0);
      step(1, 1, 32'h3F0, 0, 0, 1);
      step(1, 0, 32'h0,   1, 0, 0);
      step(1, 1, 32'h310, 1, 0, 0);
      step(1, 1, 32'h314, 1, 0, 1);
      step(1, 0, 32'h0,   1, 0, 0);

      // Single-entry: full throughput, then combinational back-pressure
      for (int i = 0; i < 8; i++) step(0, 1, 32'h400 + 32'(4 * i), 1, 0, 0);
      step(0, 0, 32'h0, 1, 0, 0);
      chk("single_throughput", consumed0, 64'd8);
      step(0, 0, 32'h0,   0, 0, 0);
      step(0, 1, 32'h500, 0, 0, 0);
      step(0, 1, 32'h504, 0, 0, 0);
      step(0, 1, 32'h504, 1, 1, 0);
      step(0, 1, 32'h504, 1, 0, 0);
      step(0, 0, 32'h0,   1, 0, 0);
      step(0, 0, 32'h0,   1, 0, 0);

      // Async reset in the middle of FULL2
      step(1, 1, 32'h600, 0, 0, 0);
      step(1, 1, 32'h604, 0, 0, 0);
      f_valid[1] = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_fd_valid", {63'd0, fd_valid[1]}, 64'd0);
      chk("midrst_fd_instr", {32'd0, fd_instr[1]}, {32'd0, NOP});
      chk("midrst_fd_pc", {32'd0, fd_pc[1]}, 64'd0);
      chk("midrst_occ", {62'd0, occ[1]}, 64'd0);
      chk("midrst_f_ready", {63'd0, f_ready[1]}, 64'd1);
      q1.delete();
      q0.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      step(1, 1, 32'h700, 1, 0, 0);
      step(1, 0, 32'h0,   1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
